// File: rtl/button_onehot_scanner_pkg.sv
// Shared types and constants for the button one-hot scanner and its encoder-side users.
package button_onehot_scanner_pkg;

  // Scanner FSM states; 3-bit encoding is shared with encoder-side benches.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_REJECT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } state_t;

  // Legal codes on the encoder input, one per button.
  localparam logic [3:0] ONEHOT_B0 = 4'b0001;
  localparam logic [3:0] ONEHOT_B1 = 4'b0010;
  localparam logic [3:0] ONEHOT_B2 = 4'b0100;
  localparam logic [3:0] ONEHOT_B3 = 4'b1000;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/button_onehot_scanner_if.sv
// Button-in / one-hot-code-out bundle between the scanner and its environment.
interface button_onehot_scanner_if;
  logic [3:0] btn;
  logic [3:0] onehot;
  logic       valid;
  logic       held;
  logic       multi_err;

  // The scanner drives the code and status, the environment drives the buttons.
  modport master (input btn, output onehot, output valid, output held, output multi_err);
  modport slave  (output btn, input onehot, input valid, input held, input multi_err);
endinterface

// File: rtl/button_onehot_scanner_sync_2ff.sv
// Two-flop synchronizer bringing asynchronous button levels into the clk domain.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Shift the raw level through two flops; synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      // NOTE: non-blocking so q takes the pre-edge meta; blocking would collapse the chain to one flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_onehot_scanner.sv
// Debounces four buttons into an always-one-hot code for the 4x2 encoder.
// Single presses are accepted, stable multi-button patterns are rejected and flagged.
module button_onehot_scanner
  import button_onehot_scanner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  button_onehot_scanner_if.master  bus
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [3:0]       sync_btn;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             err_q, err_d;

  sync_2ff #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn),
    .q     (sync_btn)
  );

  // Saturating increment: the counter stops at DEBOUNCE_CYCLES and never wraps.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    onehot_d = onehot_q;
    held_d   = held_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_btn != 4'd0) begin
          cand_d  = sync_btn;
          cnt_d   = CNT_W'(1);
          state_d = ST_PRESS_DB;
        end
      end

      ST_PRESS_DB: begin
        if (sync_btn == 4'd0) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sync_btn != cand_q) begin
          cand_d = sync_btn;
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            if (is_onehot4(cand_q)) begin
              onehot_d = cand_q;
              valid_d  = 1'b1;
              held_d   = 1'b1;
              state_d  = ST_PRESSED;
            end else begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = ST_REJECT;
            end
          end
        end
      end

      ST_PRESSED: begin
        held_d = 1'b1;
        // Release or an added button both end the press; nothing new is accepted until all-clear.
        if (sync_btn != cand_q) begin
          cnt_d   = '0;
          state_d = ST_RELEASE_DB;
        end
      end

      ST_REJECT, ST_RELEASE_DB: begin
        if (sync_btn != 4'd0) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            held_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, candidate and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= 4'd0;
      onehot_q <= ONEHOT_B0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
      err_q    <= err_d;
    end
  end

  assign bus.onehot    = onehot_q;
  assign bus.valid     = valid_q;
  assign bus.held      = held_q;
  assign bus.multi_err = err_q;

endmodule
